// File: rtl/arm_shifter.sv
// ARM-style barrel shifter for the second-operand path.
// LSL/LSR/ASR/ROR with zero-amount encodings, immediate rotate, registered out.
module arm_shifter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] Operand,
   input  logic [4:0]       Amount,
   input  logic             CIn,
   input  logic             EN,
   input  logic             STA,
   input  logic [1:0]       IR,
   output logic [WIDTH-1:0] Out,
   output logic             Cout
);

   logic [WIDTH-1:0]        res;
   logic                    res_c;
   logic [WIDTH:0]          lsl_ext;
   logic [WIDTH:0]          lsr_ext;
   logic signed [WIDTH:0]   asr_ext;
   logic [2*WIDTH-1:0]      ror_ext;
   logic [2*WIDTH-1:0]      imm_ext;
   logic [WIDTH-1:0]        imm_val;
   logic [4:0]              rot;

   // Extra bit beside the operand catches the last bit shifted out.
   assign lsl_ext = {1'b0, Operand} << Amount;
   assign lsr_ext = {Operand, 1'b0} >> Amount;
   assign asr_ext = $signed({Operand, 1'b0}) >>> Amount;
   assign ror_ext = {Operand, Operand} >> Amount;

   assign rot     = {Amount[3:0], 1'b0};
   assign imm_val = {{(WIDTH-8){1'b0}}, Operand[7:0]};
   assign imm_ext = {imm_val, imm_val} >> rot;

   always_comb begin
      res   = Operand;
      res_c = CIn;
      if (!EN) begin
         res   = Operand;
         res_c = CIn;
      end else if (STA) begin
         res   = imm_ext[WIDTH-1:0];
         res_c = (rot == 5'd0) ? CIn : imm_ext[WIDTH-1];
      end else begin
         unique case (IR)
            2'b00: begin
               res   = lsl_ext[WIDTH-1:0];
               res_c = (Amount == 5'd0) ? CIn : lsl_ext[WIDTH];
            end
            2'b01: begin
               if (Amount == 5'd0) begin
                  res   = '0;
                  res_c = Operand[WIDTH-1];
               end else begin
                  res   = lsr_ext[WIDTH:1];
                  res_c = lsr_ext[0];
               end
            end
            2'b10: begin
               if (Amount == 5'd0) begin
                  res   = {WIDTH{Operand[WIDTH-1]}};
                  res_c = Operand[WIDTH-1];
               end else begin
                  res   = asr_ext[WIDTH:1];
                  res_c = asr_ext[0];
               end
            end
            2'b11: begin
               // Amount 0 is RRX: one-bit rotate through carry.
               if (Amount == 5'd0) begin
                  res   = {CIn, Operand[WIDTH-1:1]};
                  res_c = Operand[0];
               end else begin
                  res   = ror_ext[WIDTH-1:0];
                  res_c = ror_ext[WIDTH-1];
               end
            end
            default: begin
               res   = Operand;
               res_c = CIn;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         Out  <= '0;
         Cout <= 1'b0;
      end else begin
         Out  <= res;
         Cout <= res_c;
      end
   end

endmodule

// File: tb/tb_arm_shifter.sv
// Directed-vector bench for arm_shifter.
// Vectors are issued back to back; each result is checked one edge later.
module tb_arm_shifter;

   typedef struct {
      string       name;
      logic [31:0] op;
      logic [4:0]  amt;
      logic        cin;
      logic        en;
      logic        sta;
      logic [1:0]  ir;
      logic [31:0] exp_out;
      logic        exp_c;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] operand;
   logic [4:0]  amount;
   logic        cin;
   logic        en;
   logic        sta;
   logic [1:0]  ir;
   logic [31:0] out;
   logic        cout;

   int          n_chk  = 0;
   int          n_pass = 0;
   vec_t        tbl[$];
   logic [31:0] prev_out;
   logic        prev_c;

   arm_shifter dut (
      .clk     (clk),
      .rst     (rst),
      .Operand (operand),
      .Amount  (amount),
      .CIn     (cin),
      .EN      (en),
      .STA     (sta),
      .IR      (ir),
      .Out     (out),
      .Cout    (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", nm, act, exp);
   endtask

   task automatic drive(input vec_t v);
      operand = v.op;
      amount  = v.amt;
      cin     = v.cin;
      en      = v.en;
      sta     = v.sta;
      ir      = v.ir;
   endtask

   task automatic add(input string nm, input logic [31:0] op,
                      input logic [4:0] amt, input logic c,
                      input logic e, input logic s, input logic [1:0] t,
                      input logic [31:0] eo, input logic ec);
      vec_t v;
      v.name = nm; v.op = op; v.amt = amt; v.cin = c;
      v.en = e; v.sta = s; v.ir = t;
      v.exp_out = eo; v.exp_c = ec;
      tbl.push_back(v);
   endtask

   initial begin
      //   name        operand       amt  cin en sta ir     out          c
      add("lsl2",     32'hF2345678, 2,  0, 1, 0, 2'b00, 32'hC8D159E0, 1);
      add("lsr0",     32'hF2345678, 0,  0, 1, 0, 2'b01, 32'h00000000, 1);
      add("asr3",     32'hF2345678, 3,  1, 1, 0, 2'b10, 32'hFE468ACF, 0);
      add("ror16",    32'hF2345678, 16, 1, 1, 0, 2'b11, 32'h5678F234, 0);
      add("rrx_c1",   32'hF2345678, 0,  1, 1, 0, 2'b11, 32'hF91A2B3C, 0);
      add("rrx_c0",   32'hF2345678, 0,  0, 1, 0, 2'b11, 32'h791A2B3C, 0);
      add("lsl31",    32'h00000003, 31, 0, 1, 0, 2'b00, 32'h80000000, 1);
      add("lsr31",    32'h80000000, 31, 1, 1, 0, 2'b01, 32'h00000001, 0);
      add("lsr4",     32'hF2345678, 4,  0, 1, 0, 2'b01, 32'h0F234567, 1);
      add("lsl0",     32'h12345678, 0,  1, 1, 0, 2'b00, 32'h12345678, 1);
      add("asr0_neg", 32'h80000000, 0,  0, 1, 0, 2'b10, 32'hFFFFFFFF, 1);
      add("asr0_pos", 32'h7FFFFFFF, 0,  1, 1, 0, 2'b10, 32'h00000000, 0);
      add("ror1",     32'h00000001, 1,  0, 1, 0, 2'b11, 32'h80000000, 1);
      add("imm4",     32'h000000FF, 4,  0, 1, 1, 2'b00, 32'hFF000000, 1);
      add("imm0",     32'h000000FF, 0,  0, 1, 1, 2'b10, 32'h000000FF, 0);
      add("imm_a31",  32'h000000FF, 31, 1, 1, 1, 2'b00, 32'h000003FC, 0);
      add("imm_hi",   32'hABCDEF83, 1,  0, 1, 1, 2'b01, 32'hC0000020, 1);
      add("pass",     32'hF2345678, 31, 1, 0, 0, 2'b00, 32'hF2345678, 1);
      add("pass_sta", 32'h000000FF, 5,  0, 0, 1, 2'b11, 32'h000000FF, 0);

      // Reset with arbitrary inputs held for two edges
      rst = 1'b1;
      operand = 32'hDEADBEEF; amount = 5'd7; cin = 1'b1;
      en = 1'b0; sta = 1'b0; ir = 2'b10;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         chk("rst_out", out, 32'h0);
         chk("rst_c", {31'b0, cout}, 32'h0);
      end

      @(negedge clk);
      rst = 1'b0;
      prev_out = 32'h0;
      prev_c   = 1'b0;
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         #1;
         chk({tbl[i].name, "_hold"}, out, prev_out);
         chk({tbl[i].name, "_holdc"}, {31'b0, cout}, {31'b0, prev_c});
         @(posedge clk); #1;
         chk({tbl[i].name, "_out"}, out, tbl[i].exp_out);
         chk({tbl[i].name, "_c"}, {31'b0, cout}, {31'b0, tbl[i].exp_c});
         prev_out = tbl[i].exp_out;
         prev_c   = tbl[i].exp_c;
         @(negedge clk);
      end

      // Reset mid-stream wins over a valid operation
      drive(tbl[0]);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_out", out, 32'h0);
      chk("mid_rst_c", {31'b0, cout}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(tbl[3]);
      #1;
      chk("post_rst_hold", out, 32'h0);
      @(posedge clk); #1;
      chk("post_rst_out", out, tbl[3].exp_out);
      chk("post_rst_c", {31'b0, cout}, {31'b0, tbl[3].exp_c});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/arm_shifter.md
Name: arm_shifter

Overview:
- ARM-style barrel shifter for the datapath's second-operand path.
- Applies LSL, LSR, ASR or ROR (including the ARM zero-amount special encodings) to a 32-bit operand, plus an immediate-rotate mode.
- Produces the shifted operand and the shifter carry-out consumed by the flag logic.
- Output and carry are registered: one clock of latency.

Parameters:
- WIDTH, 32, operand/result width. Behaviour is defined for 32 only; other values are unsupported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- Operand  input  32  value to be shifted/rotated.
- Amount  input  5  shift amount 0..31; in immediate-rotate mode, Amount[3:0] is the rotate field.
- CIn  input  1  current C flag; used for amount-0 LSL, RRX and pass-through.
- EN  input  1  1 = apply shift; 0 = pass Operand through unchanged.
- STA  input  1  1 = immediate-rotate mode; 0 = shift mode selected by IR.
- IR  input  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- Out  output  32  registered result.
- Cout  output  1  registered shifter carry-out.

Behaviour:
- On a rising clk with rst=1: Out<=0, Cout<=0. Reset has priority over every other input.
- Otherwise Out/Cout load the combinational result of the current inputs every cycle. Latency is exactly 1 cycle, there is no handshake, and a new operation may be issued every cycle.
- Priority: rst > EN=0 > STA=1 > IR.
- EN=0: Out=Operand, Cout=CIn. STA and IR are ignored.
- Immediate-rotate mode (EN=1, STA=1):
  - R = 2*Amount[3:0] (0..30). Amount[4] and IR are ignored.
  - Out = ROR({24'b0, Operand[7:0]}, R).
  - Cout = CIn if R=0, else Out[31].
- Shift mode (EN=1, STA=0), n = Amount:
  - LSL, n=0: Out=Operand, Cout=CIn.
  - LSL, n=1..31: Out=Operand<<n (zero fill), Cout=Operand[32-n].
  - LSR, n=0: encodes LSR #32. Out=0, Cout=Operand[31].
  - LSR, n=1..31: Out=Operand>>n (zero fill), Cout=Operand[n-1].
  - ASR, n=0: encodes ASR #32. Out = 32 copies of Operand[31], Cout=Operand[31].
  - ASR, n=1..31: sign-filled right shift, Cout=Operand[n-1].
  - ROR, n=0: encodes RRX. Out={CIn, Operand[31:1]}, Cout=Operand[0].
  - ROR, n=1..31: Out=rotate right by n, Cout=Operand[n-1] (equals Out[31]).
- All shift paths are pure functions of the inputs. The only state is the Out/Cout register.
- CIn may be fed from Cout externally; the registered output prevents a combinational loop.
- Inputs that change mid-cycle affect only the next captured result.
- Reset asserted mid-stream clears the outputs on that edge. The first valid result appears one cycle after rst deasserts.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> Out=0x00000000, Cout=0. Release rst -> Out/Cout track inputs from the next edge.
- Operand=0xF2345678, EN=1, STA=0, sweep IR/Amount:
  - LSL #2 -> Out=0xC8D159E0, Cout=1.
  - LSR #0 -> Out=0x00000000, Cout=1.
  - ASR #3 -> Out=0xFE468ACF, Cout=0.
  - ROR #16 -> Out=0x5678F234, Cout=0.
- RRX: Operand=0xF2345678, IR=11, Amount=0, CIn=1 -> Out=0xF91A2B3C, Cout=0. Same with CIn=0 -> Out=0x791A2B3C.
- Edge amounts: LSL #31 on 0x00000003 -> Out=0x80000000, Cout=1. LSR #31 on 0x80000000 -> Out=0x00000001, Cout=0.
- Immediate rotate: STA=1, Operand=0x000000FF, Amount=4 -> Out=0xFF000000, Cout=1. Amount=0, CIn=0 -> Out=0x000000FF, Cout=0.
- Pass-through: EN=0, IR=00, Amount=31, Operand=0xF2345678, CIn=1 -> Out=0xF2345678, Cout=1. Every result must appear exactly one clock after the inputs are applied.
